// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser
//   Payout side of the vending controller's coin interface. A change request
//   in 5-unit credits is paid out greedily (10-coins first) one coin at a time.
//   Each coin is ejected by a PULSE_CYC-long strobe and must be confirmed by
//   the exit sensor. A missing confirmation raises a sticky jam fault.
//   Per-hopper inventories are tracked with saturating refill loads.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  change request handshake; req_amt = credits owed
//   load_5, load_10      refill strobes; load_qty coins added per strobe
//   coin_sense           one-cycle pulse per coin seen at the exit
//   fault_clr            clears the jam fault and ends the payout short
//   eject_5, eject_10    hopper eject strobes (never both high)
//   busy                 high in every state except IDLE
//   done, short          end-of-payout pulse; short = payout incomplete
//   paid_amt             credits actually paid, held until the next accept
//   inv_5, inv_10        hopper inventories
//   exact_only           5-hopper empty
//   fault                jam fault
//
// PULSE_CYC, TIMEOUT_CYC and GAP_CYC must each be at least 1.
module vend_change_dispenser #(
  parameter int AMT_W       = 4,
  parameter int CNT_W       = 6,
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 8,
  parameter int GAP_CYC     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  input  logic             load_5,
  input  logic             load_10,
  input  logic [CNT_W-1:0] load_qty,
  input  logic             coin_sense,
  input  logic             fault_clr,
  output logic             eject_5,
  output logic             eject_10,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] paid_amt,
  output logic [CNT_W-1:0] inv_5,
  output logic [CNT_W-1:0] inv_10,
  output logic             exact_only,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_WAIT_SENSE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  // One shared timer serves the pulse, sensor timeout and gap phases.
  localparam int TMR_MAX =
    (PULSE_CYC > TIMEOUT_CYC) ? ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC)
                              : ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_CYC - 1);

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   tmr_reg, tmr_next;
  logic [AMT_W-1:0]   remaining_reg, remaining_next;
  logic [AMT_W-1:0]   paid_reg, paid_next;
  logic               coin10_reg, coin10_next;
  logic               short_reg, short_next;

  logic [1:0]         load_vec;
  logic [1:0]         dec_vec;
  logic [CNT_W-1:0]   inv_5_cur;
  logic [CNT_W-1:0]   inv_10_cur;
  logic [AMT_W-1:0]   coin_val;

  // ---------------------------------------------------------------------
  // Hopper inventories: index 0 = 5-coin hopper, index 1 = 10-coin hopper.
  // The decrement for a coin is taken on the first EJECT cycle; a load on
  // the same edge is folded in before saturation.
  // ---------------------------------------------------------------------
  assign load_vec   = {load_10, load_5};
  assign dec_vec[0] = (state_reg == S_EJECT) && (tmr_reg == '0) && !coin10_reg;
  assign dec_vec[1] = (state_reg == S_EJECT) && (tmr_reg == '0) &&  coin10_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_hopper
    logic [CNT_W-1:0] inv_reg;
    logic [CNT_W-1:0] inv_next;
    logic [CNT_W:0]   sum;

    // A decrement only happens on a non-empty hopper, so the sum cannot
    // underflow; the extra MSB flags overflow past the saturation limit.
    always_comb begin
      sum = {1'b0, inv_reg}
          + (load_vec[gi] ? {1'b0, load_qty} : '0)
          - {{CNT_W{1'b0}}, dec_vec[gi]};
      inv_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        inv_reg <= '0;
      end else begin
        inv_reg <= inv_next;
      end
    end
  end

  assign inv_5_cur  = g_hopper[0].inv_reg;
  assign inv_10_cur = g_hopper[1].inv_reg;
  assign coin_val   = coin10_reg ? AMT_W'(2) : AMT_W'(1);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      tmr_reg       <= '0;
      remaining_reg <= '0;
      paid_reg      <= '0;
      coin10_reg    <= 1'b0;
      short_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmr_reg       <= tmr_next;
      remaining_reg <= remaining_next;
      paid_reg      <= paid_next;
      coin10_reg    <= coin10_next;
      short_reg     <= short_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    tmr_next       = tmr_reg;
    remaining_next = remaining_reg;
    paid_next      = paid_reg;
    coin10_next    = coin10_reg;
    short_next     = short_reg;

    unique case (state_reg)
      S_IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone is an accept.
        if (req_valid) begin
          state_next     = S_SELECT;
          remaining_next = req_amt;
          paid_next      = '0;
          short_next     = 1'b0;
        end
      end

      S_SELECT: begin
        tmr_next = '0;
        if (remaining_reg == '0) begin
          state_next = S_DONE;
          short_next = 1'b0;
        end else if ((remaining_reg >= AMT_W'(2)) && (inv_10_cur != '0)) begin
          state_next  = S_EJECT;
          coin10_next = 1'b1;
        end else if (inv_5_cur != '0) begin
          state_next  = S_EJECT;
          coin10_next = 1'b0;
        end else begin
          state_next = S_DONE;
          short_next = 1'b1;
        end
      end

      S_EJECT: begin
        if (tmr_reg == PULSE_LAST) begin
          state_next = S_WAIT_SENSE;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end

      S_WAIT_SENSE: begin
        if (coin_sense) begin
          // SELECT only picks a coin no larger than remaining, so no underflow.
          remaining_next = remaining_reg - coin_val;
          paid_next      = paid_reg + coin_val;
          state_next     = S_GAP;
          tmr_next       = '0;
        end else if (tmr_reg == TIMEOUT_LAST) begin
          state_next = S_FAULT;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end

      S_GAP: begin
        if (tmr_reg == GAP_LAST) begin
          state_next = S_SELECT;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      S_FAULT: begin
        // The coin in flight was never confirmed, so it is not credited.
        if (fault_clr) begin
          state_next = S_DONE;
          short_next = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    // req_ready is held low while rst is asserted so nothing is taken in reset.
    req_ready  = (state_reg == S_IDLE) && !rst;
    busy       = (state_reg != S_IDLE);
    done       = (state_reg == S_DONE);
    short      = (state_reg == S_DONE) && short_reg;
    fault      = (state_reg == S_FAULT);
    eject_10   = (state_reg == S_EJECT) &&  coin10_reg;
    eject_5    = (state_reg == S_EJECT) && !coin10_reg;
    paid_amt   = paid_reg;
    inv_5      = inv_5_cur;
    inv_10     = inv_10_cur;
    exact_only = (inv_5_cur == '0);
  end

endmodule

// File: tb/tb_vend_change_dispenser.sv
`timescale 1ns/1ps
module tb_vend_change_dispenser;

  localparam int AMT_W       = 4;
  localparam int CNT_W       = 6;
  localparam int PULSE_CYC   = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int GAP_CYC     = 3;
  localparam int INV_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amt = '0;
  logic             load_5 = 1'b0;
  logic             load_10 = 1'b0;
  logic [CNT_W-1:0] load_qty = '0;
  logic             coin_sense;
  logic             fault_clr = 1'b0;
  logic             req_ready, eject_5, eject_10, busy, done, short;
  logic             exact_only, fault;
  logic [AMT_W-1:0] paid_amt;
  logic [CNT_W-1:0] inv_5, inv_10;

  always #5 clk = ~clk;

  vend_change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .load_5(load_5), .load_10(load_10), .load_qty(load_qty),
    .coin_sense(coin_sense), .fault_clr(fault_clr),
    .eject_5(eject_5), .eject_10(eject_10), .busy(busy), .done(done),
    .short(short), .paid_amt(paid_amt), .inv_5(inv_5), .inv_10(inv_10),
    .exact_only(exact_only), .fault(fault)
  );

  int checks = 0;
  int errors = 0;

  // Expectations for the current payout, written by the stimulus process.
  int exp_paid = 0, exp_short = 0, exp_i5 = 0, exp_i10 = 0, exp_n5 = 0, exp_n10 = 0;
  int lit_paid = 0, lit_short = 0, lit_i5 = 0, lit_i10 = 0;
  int exp_lat = -1;
  bit no_done = 1'b0;
  bit sensor_en = 1'b1;
  int to_cnt = 0;
  string to_name = "";
  int pin_cnt = 0;
  int pin_val = 0;
  // Stimulus-side inventory model used to derive payout expectations.
  int mm5 = 0, mm10 = 0;

  function automatic int sat(input int v);
    return (v > INV_MAX) ? INV_MAX : v;
  endfunction

  // Greedy payout: as many 10s as fit and are stocked, then 5s.
  function automatic void greedy(input int amt, input int i10, input int i5,
                                 output int n10, output int n5);
    n10 = amt / 2;
    if (n10 > i10) n10 = i10;
    n5 = amt - 2 * n10;
    if (n5 > i5) n5 = i5;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Compare process: samples on the falling edge every cycle.
  // ---------------------------------------------------------------------
  initial begin : compare
    int cyc, since, run, last_hi, sense_cyc, n5, n10, to_seen, pin_seen;
    int m5, m10, dec5, dec10;
    bit prev_strobe, prev_fault, first_seen, strobe;
    cyc = 0; since = 0; run = 0; last_hi = -100; sense_cyc = -1;
    n5 = 0; n10 = 0; to_seen = 0; pin_seen = 0; m5 = 0; m10 = 0;
    prev_strobe = 0; prev_fault = 0; first_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      dec5 = 0;
      dec10 = 0;
      if (to_cnt != to_seen) begin
        chk({"timeout_", to_name}, to_seen, to_cnt);
        to_seen = to_cnt;
      end
      if (rst) begin
        // Only exact_only (bit 23) may be high while in reset.
        chk("rst_outputs", int'({exact_only, fault, short, done, busy, eject_10, eject_5,
                                 req_ready, paid_amt, inv_5, inv_10}), 1 << 23);
        m5 = 0; m10 = 0; run = 0; prev_strobe = 0; prev_fault = 0; sense_cyc = -1;
      end else begin
        chk("inv_5", int'(inv_5), m5);
        chk("inv_10", int'(inv_10), m10);
        chk("exact_only", int'(exact_only), int'(m5 == 0));
        chk("strobe_excl", int'(eject_5 && eject_10), 0);
        chk("ready_vs_busy", int'(req_ready), int'(!busy));
        if (!done) chk("short_without_done", int'(short), 0);
        if (fault) begin
          chk("fault_strobes", int'(eject_5 || eject_10), 0);
          chk("fault_ready", int'(req_ready), 0);
        end
        if (no_done) chk("abort_no_done", int'(done), 0);

        if (req_valid && req_ready) begin
          since = 0; n5 = 0; n10 = 0; sense_cyc = -1; first_seen = 0;
        end else begin
          since++;
        end

        strobe = eject_5 || eject_10;
        if (strobe && !prev_strobe) begin
          if (eject_10) n10++; else n5++;
          if (!first_seen) begin
            first_seen = 1;
            chk("first_eject_latency", since, 2);
          end else if (sense_cyc >= 0) begin
            // GAP cycles plus one SELECT cycle between sense and next strobe.
            chk("gap_after_sense", cyc - sense_cyc, GAP_CYC + 2);
          end
          // The hopper decrement lands on the edge closing this first cycle.
          dec5 = int'(eject_5);
          dec10 = int'(eject_10);
        end
        if (strobe) begin
          run++;
          last_hi = cyc;
        end else if (run > 0) begin
          chk("pulse_width", run, PULSE_CYC);
          run = 0;
        end
        if (coin_sense && busy) sense_cyc = cyc;
        if (fault && !prev_fault) chk("fault_latency", cyc - last_hi, TIMEOUT_CYC + 1);

        if (done) begin
          chk("paid_model", int'(paid_amt), exp_paid);
          chk("short_model", int'(short), exp_short);
          chk("inv5_model", int'(inv_5), exp_i5);
          chk("inv10_model", int'(inv_10), exp_i10);
          chk("coins10_model", n10, exp_n10);
          chk("coins5_model", n5, exp_n5);
          chk("paid_literal", int'(paid_amt), lit_paid);
          chk("short_literal", int'(short), lit_short);
          chk("inv5_literal", int'(inv_5), lit_i5);
          chk("inv10_literal", int'(inv_10), lit_i10);
          if (exp_lat >= 0) chk("done_latency", since, exp_lat);
        end
        if (pin_cnt != pin_seen) begin
          chk("inv5_pin", int'(inv_5), pin_val);
          pin_seen = pin_cnt;
        end

        m5  = sat(m5  + (load_5  ? int'(load_qty) : 0) - dec5);
        m10 = sat(m10 + (load_10 ? int'(load_qty) : 0) - dec10);
        prev_strobe = strobe;
        prev_fault = fault;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Coin sensor: confirms each coin two cycles after its strobe ends.
  // ---------------------------------------------------------------------
  initial begin : sensor
    bit s_prev;
    s_prev = 0;
    coin_sense = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sensor_en && s_prev && !(eject_5 || eject_10)) begin
        repeat (2) begin @(posedge clk); #1; end
        coin_sense = 1'b1;
        @(posedge clk); #1;
        coin_sense = 1'b0;
      end
      s_prev = eject_5 || eject_10;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    mm5 = 0; mm10 = 0;
  endtask

  task automatic load(input bit h10, input int qty);
    load_qty = CNT_W'(qty);
    if (h10) load_10 = 1'b1; else load_5 = 1'b1;
    tick();
    load_5 = 1'b0; load_10 = 1'b0;
    if (h10) mm10 = sat(mm10 + qty); else mm5 = sat(mm5 + qty);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    if (!done) begin
      to_name = name;
      to_cnt++;
    end
  endtask

  task automatic request(input string name, input int amt,
                         input int p, input int s, input int i5, input int i10,
                         input int hold_extra, input int mid_load5);
    int n10, n5;
    greedy(amt, mm10, mm5, n10, n5);
    exp_n10 = n10; exp_n5 = n5;
    exp_paid = 2 * n10 + n5;
    exp_short = int'(exp_paid < amt);
    mm10 = mm10 - n10;
    mm5 = sat(mm5 + mid_load5) - n5;
    exp_i5 = mm5; exp_i10 = mm10;
    lit_paid = p; lit_short = s; lit_i5 = i5; lit_i10 = i10;
    exp_lat = (amt == 0) ? 2 : -1;
    sensor_en = 1'b1;
    req_amt = AMT_W'(amt);
    req_valid = 1'b1;
    tick();
    if (mid_load5 > 0) begin
      // Load lands on the same edge as the first coin's decrement.
      req_valid = 1'b0;
      tick();
      load_qty = CNT_W'(mid_load5);
      load_5 = 1'b1;
      tick();
      load_5 = 1'b0;
    end
    for (int i = 0; i < hold_extra; i++) begin
      req_amt = AMT_W'(amt + 5);
      tick();
    end
    req_valid = 1'b0;
    wait_done(name, 300);
    tick();
  endtask

  initial begin : stim
    bit seen;
    do_reset();

    // Mixed payout: one 10, one 5.
    load(1, 3); load(0, 3);
    request("mixed", 3, 3, 0, 2, 2, 0, 0);

    // Only 5s stocked; extra req_valid while busy must be ignored.
    do_reset();
    load(0, 5);
    request("fives", 4, 4, 0, 1, 0, 3, 0);

    // Shortfall: one 10 then both hoppers empty.
    do_reset();
    load(1, 1);
    request("short", 3, 2, 1, 0, 0, 0, 0);

    // Jam: no sensor confirmation.
    do_reset();
    load(1, 2);
    sensor_en = 1'b0;
    exp_paid = 0; exp_short = 1; exp_n10 = 1; exp_n5 = 0;
    mm10 = 1; exp_i10 = 1; exp_i5 = 0; exp_lat = -1;
    lit_paid = 0; lit_short = 1; lit_i5 = 0; lit_i10 = 1;
    req_amt = AMT_W'(2);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = fault;
    end
    if (!seen) begin to_name = "fault_rise"; to_cnt++; end
    repeat (3) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    wait_done("fault_clr", 10);
    tick();
    sensor_en = 1'b1;

    // Zero request, then saturating refill.
    request("zero", 0, 0, 0, 0, 1, 0, 0);
    load(0, 10);
    load(0, 63);
    pin_val = 63;
    pin_cnt++;
    tick();

    // Refill coincident with the first decrement on the same hopper.
    do_reset();
    load(0, 3);
    request("load_during_eject", 2, 2, 0, 5, 0, 0, 4);

    // Reset in the middle of a payout.
    do_reset();
    load(1, 2); load(0, 2);
    req_amt = AMT_W'(4);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = eject_5 || eject_10;
    end
    if (!seen) begin to_name = "abort_strobe"; to_cnt++; end
    tick(); tick();
    no_done = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    no_done = 1'b0;
    mm5 = 0; mm10 = 0;
    load(0, 2);
    request("after_abort", 1, 1, 0, 1, 0, 0, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
